// File: rtl/fft_result_collector_pkg.sv
// Shared definitions for the FFT result collector: FSM states, dimension
// encodings and default geometry of one dimension pass.
package fft_result_collector_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned FRAME_LEN_DEF  = 32;
    localparam int unsigned NUM_FRAMES_DEF = 32;
    localparam int unsigned TIMEOUT_DEF    = 128;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DIM_W  = 3;
    localparam int unsigned FCNT_W = 6;
    localparam int unsigned IDX_W  = 5;

    localparam logic [DIM_W-1:0] DIM_X = 3'b001;
    localparam logic [DIM_W-1:0] DIM_Y = 3'b010;
    localparam logic [DIM_W-1:0] DIM_Z = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOP = 2'd1,
        ST_IN_FRAME = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // Y passes are stored transposed; X and Z share the row-major layout.
    function automatic logic dim_is_transposed(input logic [DIM_W-1:0] dim);
        return dim == DIM_Y;
    endfunction

endpackage

// File: rtl/fft_result_collector_if.sv
// Source stream from the FFT core into the collector.
interface fft_result_collector_if
    import fft_result_collector_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              src_valid;
    logic              src_sop;
    logic              src_eop;
    logic [DATA_W-1:0] src_real;
    logic [DATA_W-1:0] src_imag;
    logic              src_ready;

    modport master (
        output src_valid, src_sop, src_eop, src_real, src_imag,
        input  src_ready
    );

    modport slave (
        input  src_valid, src_sop, src_eop, src_real, src_imag,
        output src_ready
    );
endinterface

// File: rtl/fft_wb_addr_gen.sv
// Grid-memory address for one sample: row-major for X/Z, transposed for Y.
module fft_wb_addr_gen
    import fft_result_collector_pkg::*;
(
    input  logic [DIM_W-1:0]  dim,
    input  logic [IDX_W-1:0]  frame,
    input  logic [IDX_W-1:0]  point,
    output logic [ADDR_W-1:0] wr_addr_c
);
    always_comb begin
        if (dim_is_transposed(dim)) begin
            wr_addr_c = {1'b0, point, frame};
        end else begin
            wr_addr_c = {1'b0, frame, point};
        end
    end
endmodule

// File: rtl/fft_result_collector.sv
// Collects one dimension pass of FFT output frames into the grid memory,
// checking sop/eop framing and source stalls along the way.
module fft_result_collector
    import fft_result_collector_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FRAME_LEN  = FRAME_LEN_DEF,
    parameter int unsigned NUM_FRAMES = NUM_FRAMES_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_W-1:0]      dim,
    input  logic                  direction,
    fft_result_collector_if.slave src,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_real,
    output logic [DATA_W-1:0]     wr_imag,
    output logic                  busy,
    output logic                  done,
    output logic                  err_framing,
    output logic                  err_timeout,
    output logic [FCNT_W-1:0]     frame_cnt
);
    localparam int unsigned P_W    = $clog2(FRAME_LEN);
    localparam int unsigned SHIFT  = $clog2(FRAME_LEN);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [DIM_W-1:0]    dim_q, dim_d;
    logic                dir_q, dir_d;
    logic [P_W-1:0]      p_q, p_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                err_framing_q, err_framing_d;
    logic                err_timeout_q, err_timeout_d;
    logic                src_ready_q, src_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_real_q, wr_real_d;
    logic [DATA_W-1:0]   wr_imag_q, wr_imag_d;

    logic                accept;
    logic                last;
    logic [P_W-1:0]      pt;
    logic [FCNT_W-1:0]   frame_nxt;
    logic [IDLE_W-1:0]   idle_inc;
    logic [ADDR_W-1:0]   addr_c;

    // A sop beat always lands on point 0, whether it opens or restarts a frame.
    assign accept    = src.src_valid && src_ready_q;
    assign pt        = src.src_sop ? '0 : p_q;
    assign last      = (pt == P_W'(FRAME_LEN - 1));
    assign frame_nxt = (frame_cnt_q >= FCNT_W'(NUM_FRAMES)) ? frame_cnt_q
                                                            : FCNT_W'(frame_cnt_q + 1'b1);
    assign idle_inc  = IDLE_W'(idle_q + 1'b1);

    fft_wb_addr_gen u_addr_gen (
        .dim       (dim_q),
        .frame     (frame_cnt_q[IDX_W-1:0]),
        .point     (IDX_W'(pt)),
        .wr_addr_c (addr_c)
    );

    always_comb begin
        state_d       = state_q;
        dim_d         = dim_q;
        dir_d         = dir_q;
        p_d           = p_q;
        frame_cnt_d   = frame_cnt_q;
        idle_d        = idle_q;
        err_framing_d = err_framing_q;
        err_timeout_d = err_timeout_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_real_d     = wr_real_q;
        wr_imag_d     = wr_imag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_WAIT_SOP;
                    dim_d         = dim;
                    dir_d         = direction;
                    p_d           = '0;
                    frame_cnt_d   = '0;
                    idle_d        = '0;
                    err_framing_d = 1'b0;
                    err_timeout_d = 1'b0;
                end
            end
            ST_WAIT_SOP, ST_IN_FRAME: begin
                if (accept) begin
                    idle_d = '0;
                    if ((state_q == ST_WAIT_SOP) && !src.src_sop) begin
                        err_framing_d = 1'b1;
                    end else begin
                        if ((state_q == ST_IN_FRAME) && src.src_sop) begin
                            err_framing_d = 1'b1;
                        end
                        if (src.src_eop != last) begin
                            err_framing_d = 1'b1;
                        end
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_c;
                        wr_real_d = dir_q ? DATA_W'($signed(src.src_real) >>> SHIFT) : src.src_real;
                        wr_imag_d = dir_q ? DATA_W'($signed(src.src_imag) >>> SHIFT) : src.src_imag;
                        if (src.src_eop || last) begin
                            p_d         = '0;
                            frame_cnt_d = frame_nxt;
                            state_d     = (frame_nxt >= FCNT_W'(NUM_FRAMES)) ? ST_DONE : ST_WAIT_SOP;
                        end else begin
                            p_d     = P_W'(pt + 1'b1);
                            state_d = ST_IN_FRAME;
                        end
                    end
                end else begin
                    idle_d = idle_inc;
                    if (idle_inc >= IDLE_W'(TIMEOUT)) begin
                        err_timeout_d = 1'b1;
                        state_d       = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        src_ready_d = (state_d == ST_WAIT_SOP) || (state_d == ST_IN_FRAME);
        busy_d      = src_ready_d;
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dim_q         <= DIM_X;
            dir_q         <= 1'b0;
            p_q           <= '0;
            frame_cnt_q   <= '0;
            idle_q        <= '0;
            err_framing_q <= 1'b0;
            err_timeout_q <= 1'b0;
            src_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_real_q     <= '0;
            wr_imag_q     <= '0;
        end else begin
            state_q       <= state_d;
            dim_q         <= dim_d;
            dir_q         <= dir_d;
            p_q           <= p_d;
            frame_cnt_q   <= frame_cnt_d;
            idle_q        <= idle_d;
            err_framing_q <= err_framing_d;
            err_timeout_q <= err_timeout_d;
            src_ready_q   <= src_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_real_q     <= wr_real_d;
            wr_imag_q     <= wr_imag_d;
        end
    end

    assign src.src_ready = src_ready_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_real       = wr_real_q;
    assign wr_imag       = wr_imag_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_framing   = err_framing_q;
    assign err_timeout   = err_timeout_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_fft_result_collector.sv
// Directed bench for fft_result_collector: clean X pass, Y iFFT scaling,
// framing errors, timeout, mid-frame reset and ignored restart.
module tb_fft_result_collector;
    import fft_result_collector_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        dim = 3'b001;
    logic              direction = 1'b0;
    logic              wr_en;
    logic [10:0]       wr_addr;
    logic [31:0]       wr_real;
    logic [31:0]       wr_imag;
    logic              busy;
    logic              done;
    logic              err_framing;
    logic              err_timeout;
    logic [5:0]        frame_cnt;

    int passed = 0;
    int total  = 0;

    fft_result_collector_if #(.DATA_W(32)) src_if ();

    fft_result_collector dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dim         (dim),
        .direction   (direction),
        .src         (src_if.slave),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_real     (wr_real),
        .wr_imag     (wr_imag),
        .busy        (busy),
        .done        (done),
        .err_framing (err_framing),
        .err_timeout (err_timeout),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sop, input logic eop, input int re, input int im);
        src_if.src_valid = 1'b1;
        src_if.src_sop   = sop;
        src_if.src_eop   = eop;
        src_if.src_real  = 32'(re);
        src_if.src_imag  = 32'(im);
        tick();
    endtask

    task automatic idle_cycle();
        src_if.src_valid = 1'b0;
        src_if.src_sop   = 1'b0;
        src_if.src_eop   = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic [2:0] d, input logic dir);
        src_if.src_valid = 1'b0;
        start     = 1'b1;
        dim       = d;
        direction = dir;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        src_if.src_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int p = 0; p < 32; p++) begin
                send(p == 0, p == 31, f * 32 + p, p);
            end
        end
    endtask

    initial begin
        src_if.src_valid = 1'b0;
        src_if.src_sop   = 1'b0;
        src_if.src_eop   = 1'b0;
        src_if.src_real  = '0;
        src_if.src_imag  = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_wr", {wr_en, wr_addr, wr_real, wr_imag}, '0);
        chk("rst_status", {src_if.src_ready, busy, done, err_framing, err_timeout, frame_cnt}, '0);

        // Clean X pass, FFT direction, sample k = (k,-k)
        do_start(3'b001, 1'b0);
        chk("x_start", {busy, src_if.src_ready, done}, {1'b1, 1'b1, 1'b0});
        for (int k = 0; k < 1024; k++) begin
            send((k % 32) == 0, (k % 32) == 31, k, -k);
            chk("x_beat", {wr_en, wr_addr, wr_real, wr_imag},
                {1'b1, 11'(k), 32'(k), 32'(-k)});
        end
        chk("x_done", {done, busy, frame_cnt, err_framing, err_timeout},
            {1'b1, 1'b0, 6'd32, 1'b0, 1'b0});
        idle_cycle();
        chk("x_after", {done, busy, src_if.src_ready, wr_en}, '0);

        // Y pass, iFFT scaling
        do_start(3'b010, 1'b1);
        send_frames(1);
        send(1'b1, 1'b0, 0, 0);
        send(1'b0, 1'b0, 0, 0);
        send(1'b0, 1'b0, 64, -64);
        chk("y_p2", {wr_en, wr_addr, wr_real, wr_imag},
            {1'b1, 11'h041, 32'd2, 32'hFFFF_FFFE});
        idle_cycle();
        chk("y_p2_once", {wr_en}, {1'b0});
        send(1'b0, 1'b0, -33, 31);
        chk("y_p3", {wr_en, wr_addr, wr_real, wr_imag},
            {1'b1, 11'h061, 32'hFFFF_FFFE, 32'd0});

        // Early eop, then restart via sop inside a frame
        do_reset();
        do_start(3'b001, 1'b0);
        for (int p = 0; p < 20; p++) send(p == 0, 1'b0, p, 0);
        chk("eop_pre", {err_framing, frame_cnt}, {1'b0, 6'd0});
        send(1'b0, 1'b1, 20, 0);
        chk("eop_early", {err_framing, frame_cnt, busy}, {1'b1, 6'd1, 1'b1});
        send(1'b1, 1'b0, 7, 8);
        chk("eop_next_sop", {wr_en, wr_addr, wr_real, wr_imag},
            {1'b1, 11'h020, 32'd7, 32'd8});
        send(1'b0, 1'b0, 1, 1);
        send(1'b0, 1'b0, 2, 2);
        send(1'b1, 1'b0, 9, 10);
        chk("sop_restart", {wr_en, wr_addr, wr_real, wr_imag, frame_cnt},
            {1'b1, 11'h020, 32'd9, 32'd10, 6'd1});

        // Beat without sop, then source stall after frame 3
        do_reset();
        do_start(3'b001, 1'b0);
        send(1'b0, 1'b0, 5, 5);
        chk("nosop", {wr_en, err_framing}, {1'b0, 1'b1});
        send_frames(4);
        chk("to_frames", {frame_cnt, err_timeout}, {6'd4, 1'b0});
        src_if.src_valid = 1'b0;
        for (int i = 0; i < 127; i++) tick();
        chk("to_127", {err_timeout, busy, done}, {1'b0, 1'b1, 1'b0});
        tick();
        chk("to_128", {err_timeout, busy, done}, {1'b1, 1'b0, 1'b1});
        tick();
        chk("to_after", {done, err_timeout, err_framing, busy}, {1'b0, 1'b1, 1'b1, 1'b0});
        do_start(3'b001, 1'b0);
        chk("start_clears", {err_timeout, err_framing, frame_cnt, busy}, {1'b0, 1'b0, 6'd0, 1'b1});

        // Ignored start mid-frame, then reset at frame 10 point 15
        send_frames(10);
        for (int p = 0; p < 5; p++) send(p == 0, 1'b0, p, p);
        start = 1'b1;
        dim   = 3'b010;
        send(1'b0, 1'b0, 5, 5);
        start = 1'b0;
        chk("busy_start", {wr_en, wr_addr, busy, frame_cnt}, {1'b1, 11'h145, 1'b1, 6'd10});
        for (int p = 6; p < 15; p++) send(1'b0, 1'b0, p, p);
        chk("pre_rst", {wr_addr, err_framing}, {11'h14E, 1'b0});
        rst = 1'b1;
        send(1'b0, 1'b0, 15, 15);
        rst = 1'b0;
        chk("rst_wr_mid", {wr_en, wr_addr, wr_real, wr_imag}, '0);
        chk("rst_status_mid", {src_if.src_ready, busy, done, err_framing, err_timeout, frame_cnt}, '0);
        send(1'b1, 1'b0, 16, 16);
        chk("rst_idle", {wr_en, src_if.src_ready, busy}, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fft_result_collector.md
FFT_RESULT_COLLECTOR -- requirements
Module: fft_result_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each real/imag sample.
REQ-002 SHALL have parameter FRAME_LEN, default 32, points per FFT frame.
REQ-003 SHALL have parameter NUM_FRAMES, default 32, frames per dimension pass (1024 points).
REQ-004 SHALL have parameter TIMEOUT, default 128, maximum idle cycles between beats.
REQ-005 SHALL have one clock; reset is synchronous and active-high: clk  in  1  clock; rst  in  1  reset.
REQ-006 SHALL have start  in  1  one-cycle pulse that arms one dimension pass.
REQ-007 SHALL have dim  in  3  one-hot dimension select (001 X, 010 Y, 100 Z), sampled on start.
REQ-008 SHALL have direction  in  1  0 FFT, 1 iFFT, sampled on start.
REQ-009 SHALL have src_valid, src_sop, src_eop  in  1 each  FFT core source-stream qualifiers.
REQ-010 SHALL have src_real, src_imag  in  DATA_W each  signed FFT output samples.
REQ-011 SHALL have src_ready  out  1  stream ready to FFT core.
REQ-012 SHALL have wr_en  out  1; wr_addr  out  11; wr_real, wr_imag  out  DATA_W  grid-memory write port.
REQ-013 SHALL have busy, done  out  1; err_framing, err_timeout  out  1 sticky; frame_cnt  out  6.

Function
REQ-014 SHALL implement states IDLE, WAIT_SOP, IN_FRAME, DONE.
REQ-015 IDLE: start -> WAIT_SOP, latch dim/direction, clear frame_cnt, point counter, both error flags; start in any other state SHALL be ignored.
REQ-016 src_ready SHALL be 1 exactly in WAIT_SOP and IN_FRAME; a beat is accepted when src_valid && src_ready.
REQ-017 WAIT_SOP: accepted beat with src_sop -> write as point 0, go IN_FRAME; without src_sop -> beat dropped, err_framing set.
REQ-018 IN_FRAME: each accepted beat writes at point counter p, p increments; beat with src_eop, or p==FRAME_LEN-1, closes the frame: frame_cnt+1, p cleared, -> WAIT_SOP, or DONE if frame_cnt reaches NUM_FRAMES.
REQ-019 Framing errors SHALL set err_framing: eop with p!=FRAME_LEN-1 (frame still closed); p==FRAME_LEN-1 without eop (frame still closed); sop in IN_FRAME (beat written as point 0 of a restarted frame, frame_cnt unchanged).
REQ-020 Address: X and Z SHALL give wr_addr={1'b0,frame[4:0],p[4:0]}; Y SHALL give {1'b0,p[4:0],frame[4:0]}.
REQ-021 direction=1 SHALL arithmetic-shift real and imag right by log2(FRAME_LEN) (5) before write; direction=0 SHALL pass unchanged.
REQ-022 Write latency SHALL be exactly 1 cycle: wr_en/wr_addr/wr_real/wr_imag registered from the accepted beat; wr_en=0 otherwise.
REQ-023 Idle counter SHALL count cycles without an accepted beat in WAIT_SOP/IN_FRAME; reaching TIMEOUT SHALL set err_timeout and go DONE.
REQ-024 DONE SHALL assert done for exactly one cycle, then -> IDLE; busy=1 in WAIT_SOP and IN_FRAME only.
REQ-025 frame_cnt SHALL saturate at NUM_FRAMES; error flags SHALL hold until next accepted start or reset.

Reset
REQ-026 rst SHALL force IDLE, counters 0, src_ready/wr_en/busy/done/err_framing/err_timeout 0, wr_addr/wr_real/wr_imag 0, in any state including mid-frame; no write SHALL follow reset.

Structure
REQ-027 State enum, dim one-hot encodings, FRAME_LEN/NUM_FRAMES/TIMEOUT defaults SHALL live in the shared long-range package.
REQ-028 Address generation SHALL be one sub-module, fft_wb_addr_gen (dim, frame, point -> wr_addr); all else in one module.

Verification
REQ-029 start dim=001 dir=0, 32 clean frames of 32 beats, sample k=(k,-k) -> 1024 writes, addr k, data unchanged, one done pulse, no errors.
REQ-030 dim=010 dir=1, frame 1 point 2 value (64,-64) -> wr_addr=0x041, wr_real=2, wr_imag=-2, one cycle after acceptance.
REQ-031 frame 0 with eop at p=20 -> err_framing=1, frame_cnt=1, next sop writes point 0 of frame 1.
REQ-032 valid beat without sop in WAIT_SOP -> no wr_en, err_framing=1; stalled source 128 cycles after frame 3 -> err_timeout=1, done pulse.
REQ-033 rst at frame 10 point 15 -> next cycle all outputs 0, state IDLE; second start during busy ignored.
